// File: rtl/lsu_exec.sv
// -----------------------------------------------------------------------------
// lsu_exec -- single-op load/store execution unit.
//
// Accepts one memory op from the issue stage, performs one dcache access
// (byte-lane write mask and data alignment for stores, lane extraction and
// sign/zero extension for loads), then holds the result on a valid/ready
// writeback port until it is taken.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   issue_valid        op offered by issue stage
//   dmem_rdy           unit accepts an op this cycle (IDLE only)
//   issue_addr         effective byte address
//   issue_wdata        unaligned (LSB-justified) store data
//   issue_funct3       width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   issue_is_store     1 = store, 0 = load
//   issue_tag          ROB destination tag
//   flush              kill the in-flight op
//   dcache_addr/re/we/din   word-aligned dcache request
//   dcache_stall       dcache hold; request stays stable while high
//   dcache_dout        dcache read data, valid the cycle after dcache_re
//   wb_valid/rdy       writeback handshake
//   wb_tag/data/exc    writeback payload
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word ops skip
//                         the dcache and write back wb_exc=1, wb_data=addr.
//                         When undefined, misaligned ops are aligned down
//                         and wb_exc is tied to 0.
// -----------------------------------------------------------------------------
module lsu_exec #(
  parameter int TAG_W         = 6,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     dmem_rdy,
  input  logic [CPU_ADDR_BITS-1:0] issue_addr,
  input  logic [CPU_DATA_BITS-1:0] issue_wdata,
  input  logic [2:0]               issue_funct3,
  input  logic                     issue_is_store,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     flush,
  output logic [CPU_ADDR_BITS-1:0] dcache_addr,
  output logic                     dcache_re,
  output logic [3:0]               dcache_we,
  output logic [CPU_DATA_BITS-1:0] dcache_din,
  input  logic                     dcache_stall,
  input  logic [CPU_DATA_BITS-1:0] dcache_dout,
  output logic                     wb_valid,
  input  logic                     wb_rdy,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [CPU_DATA_BITS-1:0] wb_data,
  output logic                     wb_exc
);

  typedef enum logic [1:0] {IDLE, ACCESS, LDATA, RESP} state_t;

  state_t                   state_q, state_d;
  logic [CPU_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CPU_DATA_BITS-1:0] wdata_q, wdata_d;
  logic [2:0]               funct3_q, funct3_d;
  logic                     is_store_q, is_store_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [CPU_DATA_BITS-1:0] data_q, data_d;

  logic [3:0]               mask;
  logic [1:0]               lane_off;
  logic [CPU_DATA_BITS-1:0] lane_data;
  logic [CPU_DATA_BITS-1:0] load_data;
  logic                     in_access;

  // Byte mask and lane offset. Halfwords and words are aligned down to their
  // natural boundary; the same offset is used for store data placement and
  // load data extraction so both sides agree on a misaligned address.
  always_comb begin
    mask     = 4'b1111;
    lane_off = 2'b00;
    case (funct3_q[1:0])
      2'b00: begin
        mask     = 4'b0001 << addr_q[1:0];
        lane_off = addr_q[1:0];
      end
      2'b01: begin
        mask     = 4'b0011 << {addr_q[1], 1'b0};
        lane_off = {addr_q[1], 1'b0};
      end
      default: begin
        mask     = 4'b1111;
        lane_off = 2'b00;
      end
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    lane_data = dcache_dout >> {lane_off, 3'b000};
    load_data = lane_data;
    case (funct3_q)
      3'b000:  load_data = {{(CPU_DATA_BITS-8){lane_data[7]}},   lane_data[7:0]};
      3'b001:  load_data = {{(CPU_DATA_BITS-16){lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {{(CPU_DATA_BITS-8){1'b0}},           lane_data[7:0]};
      3'b101:  load_data = {{(CPU_DATA_BITS-16){1'b0}},          lane_data[15:0]};
      default: load_data = lane_data;
    endcase
  end

  // Flush kills the request and the writeback combinationally, in the same
  // cycle, and also blocks acceptance.
  assign in_access   = (state_q == ACCESS) && !flush;
  assign dmem_rdy    = (state_q == IDLE) && !flush;
  assign dcache_re   = in_access && !is_store_q;
  assign dcache_we   = (in_access && is_store_q) ? mask : 4'b0000;
  assign dcache_addr = {addr_q[CPU_ADDR_BITS-1:2], 2'b00};
  assign dcache_din  = wdata_q << {lane_off, 3'b000};
  assign wb_valid    = (state_q == RESP) && !flush;
  assign wb_tag      = tag_q;
  assign wb_data     = data_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic exc_q, exc_d;
  logic issue_misaligned;

  assign issue_misaligned = (issue_funct3[1:0] == 2'b01 && issue_addr[0]) ||
                            (issue_funct3[1] && (issue_addr[1:0] != 2'b00));
  assign wb_exc = exc_q;
`else
  assign wb_exc = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    tag_d      = tag_q;
    data_d     = data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    exc_d      = exc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!flush && issue_valid) begin
          addr_d     = issue_addr;
          wdata_d    = issue_wdata;
          funct3_d   = issue_funct3;
          is_store_d = issue_is_store;
          tag_d      = issue_tag;
          data_d     = '0;
          state_d    = ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          exc_d      = 1'b0;
          if (issue_misaligned) begin
            // Trap straight to writeback without touching the dcache.
            exc_d   = 1'b1;
            data_d  = CPU_DATA_BITS'(issue_addr);
            state_d = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!dcache_stall) begin
          if (is_store_q) begin
            data_d  = '0;
            state_d = RESP;
          end else begin
            state_d = LDATA;
          end
        end
      end
      LDATA: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          data_d  = load_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush || wb_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_q      <= exc_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_exec.sv
// -----------------------------------------------------------------------------
// tb_lsu_exec -- directed self-checking bench for lsu_exec.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time
// unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_lsu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        dmem_rdy;
  logic [31:0] issue_addr;
  logic [31:0] issue_wdata;
  logic [2:0]  issue_funct3;
  logic        issue_is_store;
  logic [5:0]  issue_tag;
  logic        flush;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic        dcache_stall;
  logic [31:0] dcache_dout;
  logic        wb_valid;
  logic        wb_rdy;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        wb_exc;

  int checks   = 0;
  int failures = 0;

  // Observations gathered by do_op while the op is in flight.
  int          re_cnt;
  int          we_cnt;
  logic [3:0]  last_we;
  logic [31:0] last_din;
  logic [31:0] last_daddr;

  always #5 clk = ~clk;

  lsu_exec #(.TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .dmem_rdy(dmem_rdy),
    .issue_addr(issue_addr), .issue_wdata(issue_wdata),
    .issue_funct3(issue_funct3), .issue_is_store(issue_is_store),
    .issue_tag(issue_tag), .flush(flush),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re),
    .dcache_we(dcache_we), .dcache_din(dcache_din),
    .dcache_stall(dcache_stall), .dcache_dout(dcache_dout),
    .wb_valid(wb_valid), .wb_rdy(wb_rdy), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-18s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Offer one op, wait (bounded) for writeback, check latency and payload,
  // then take it with wb_rdy and confirm the unit is idle again.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic st, input logic [5:0] tg,
                       input logic [31:0] dout, input int exp_lat,
                       input logic [31:0] exp_data, input logic exp_exc);
    int lat;
    issue_valid = 1'b1; issue_addr = a; issue_wdata = wd; issue_funct3 = f3;
    issue_is_store = st; issue_tag = tg; dcache_dout = dout;
    #1;
    chk({nm, "_rdy"}, 32'(dmem_rdy), 32'd1);
    tick();
    issue_valid = 1'b0;
    lat = 1; re_cnt = 0; we_cnt = 0; last_we = '0; last_din = '0; last_daddr = '0;
    while (wb_valid !== 1'b1 && lat < 20) begin
      if (dcache_re === 1'b1) begin
        re_cnt++;
        last_daddr = dcache_addr;
      end
      if (dcache_we !== 4'b0000) begin
        we_cnt++;
        last_we = dcache_we; last_din = dcache_din; last_daddr = dcache_addr;
      end
      tick();
      lat++;
    end
    chk({nm, "_lat"},  32'(lat),    32'(exp_lat));
    chk({nm, "_data"}, wb_data,     exp_data);
    chk({nm, "_tag"},  32'(wb_tag), 32'(tg));
    chk({nm, "_exc"},  32'(wb_exc), 32'(exp_exc));
    wb_rdy = 1'b1;
    tick();
    wb_rdy = 1'b0;
    #1;
    chk({nm, "_wbdone"}, 32'(wb_valid), 32'd0);
    chk({nm, "_idle"},   32'(dmem_rdy), 32'd1);
    $display("op %s addr=0x%08h lat=%0d data=0x%08h exc=%0b", nm, a, lat, wb_data, wb_exc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_addr = '0; issue_wdata = '0;
    issue_funct3 = '0; issue_is_store = 1'b0; issue_tag = '0; flush = 1'b0;
    dcache_stall = 1'b0; dcache_dout = '0; wb_rdy = 1'b0;

    // Reset state.
    #2;
    chk("rst_rdy",   32'(dmem_rdy),  32'd1);
    chk("rst_re",    32'(dcache_re), 32'd0);
    chk("rst_we",    32'(dcache_we), 32'd0);
    chk("rst_wbv",   32'(wb_valid),  32'd0);
    chk("rst_exc",   32'(wb_exc),    32'd0);
    chk("rst_tag",   32'(wb_tag),    32'd0);
    chk("rst_data",  wb_data,        32'd0);
    chk("rst_daddr", dcache_addr,    32'd0);
    chk("rst_din",   dcache_din,     32'd0);
    #1 rst = 1'b0;
    tick();

    // LW 0x100: one read cycle, writeback 3 cycles after acceptance.
    do_op("lw100", 32'h100, 32'h0, 3'b010, 1'b0, 6'd5, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0);
    chk("lw100_recnt", 32'(re_cnt), 32'd1);
    chk("lw100_daddr", last_daddr,  32'h100);

    // Byte/halfword loads with sign and zero extension.
    do_op("lb103",  32'h103, 32'h0, 3'b000, 1'b0, 6'd1, 32'h80000000, 3, 32'hFFFFFF80, 1'b0);
    chk("lb103_daddr", last_daddr, 32'h100);
    do_op("lbu103", 32'h103, 32'h0, 3'b100, 1'b0, 6'd2, 32'h80000000, 3, 32'h00000080, 1'b0);
    do_op("lb101",  32'h101, 32'h0, 3'b000, 1'b0, 6'd3, 32'h00007F00, 3, 32'h0000007F, 1'b0);
    do_op("lh102",  32'h102, 32'h0, 3'b001, 1'b0, 6'd4, 32'h80010000, 3, 32'hFFFF8001, 1'b0);
    do_op("lhu102", 32'h102, 32'h0, 3'b101, 1'b0, 6'd6, 32'h80010000, 3, 32'h00008001, 1'b0);

    // SH 0x202: upper-half lane mask and shifted data; store writes back 0.
    do_op("sh202", 32'h202, 32'h1234, 3'b001, 1'b1, 6'd8, 32'hFFFFFFFF, 2, 32'h0, 1'b0);
    chk("sh202_we",    32'(last_we), 32'hC);
    chk("sh202_din",   last_din,     32'h12340000);
    chk("sh202_wecnt", 32'(we_cnt),  32'd1);
    chk("sh202_daddr", last_daddr,   32'h200);

    // SB 0x201.
    do_op("sb201", 32'h201, 32'hAB, 3'b000, 1'b1, 6'd9, 32'h0, 2, 32'h0, 1'b0);
    chk("sb201_we",  32'(last_we), 32'h2);
    chk("sb201_din", last_din,     32'h0000AB00);

    // Misaligned LW 0x101.
`ifdef LSU_MISALIGN_TRAP_EN
    do_op("lw101", 32'h101, 32'h0, 3'b010, 1'b0, 6'd10, 32'hDEADBEEF, 1, 32'h101, 1'b1);
    chk("lw101_recnt", 32'(re_cnt), 32'd0);
`else
    do_op("lw101", 32'h101, 32'h0, 3'b010, 1'b0, 6'd10, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0);
    chk("lw101_recnt", 32'(re_cnt), 32'd1);
    chk("lw101_daddr", last_daddr,  32'h100);
`endif

    // SW 0x300 with a 3-cycle stall, then wb_rdy held low for 2 cycles.
    issue_valid = 1'b1; issue_addr = 32'h300; issue_wdata = 32'hCAFEF00D;
    issue_funct3 = 3'b010; issue_is_store = 1'b1; issue_tag = 6'd7;
    tick();
    issue_valid = 1'b0; dcache_stall = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sws_we",    32'(dcache_we), 32'hF);
      chk("sws_din",   dcache_din,     32'hCAFEF00D);
      chk("sws_daddr", dcache_addr,    32'h300);
      if (dcache_we != 4'b0000) we_cnt++;
      tick();
    end
    dcache_stall = 1'b0;
    #1;
    chk("sws_we_last", 32'(dcache_we), 32'hF);
    if (dcache_we != 4'b0000) we_cnt++;
    chk("sws_wecnt", 32'(we_cnt), 32'd4);
    tick();
    chk("sws_after_we", 32'(dcache_we), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("sws_hold_v",   32'(wb_valid), 32'd1);
      chk("sws_hold_d",   wb_data,       32'd0);
      chk("sws_hold_tag", 32'(wb_tag),   32'd7);
      tick();
    end
    wb_rdy = 1'b1;
    chk("sws_take_v", 32'(wb_valid), 32'd1);
    tick();
    wb_rdy = 1'b0;
    chk("sws_done_v",   32'(wb_valid), 32'd0);
    chk("sws_done_rdy", 32'(dmem_rdy), 32'd1);
    $display("op sw_stall addr=0x00000300 writes=%0d", we_cnt);

    // Flush in ACCESS under stall.
    issue_valid = 1'b1; issue_addr = 32'h400; issue_wdata = 32'h55; issue_tag = 6'd11;
    issue_funct3 = 3'b010; issue_is_store = 1'b1;
    tick();
    issue_valid = 1'b0; dcache_stall = 1'b1;
    chk("fl_pre_we", 32'(dcache_we), 32'hF);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_we",  32'(dcache_we), 32'd0);
    chk("fl_re",  32'(dcache_re), 32'd0);
    chk("fl_wbv", 32'(wb_valid),  32'd0);
    tick();
    flush = 1'b0; dcache_stall = 1'b0;
    #1;
    chk("fl_next_rdy", 32'(dmem_rdy), 32'd1);
    chk("fl_next_wbv", 32'(wb_valid), 32'd0);
    chk("fl_next_we",  32'(dcache_we), 32'd0);
    $display("op flush_access addr=0x00000400");

    // Flush has priority over acceptance in IDLE.
    issue_valid = 1'b1; issue_addr = 32'h500; issue_funct3 = 3'b010;
    issue_is_store = 1'b0; flush = 1'b1;
    #1;
    chk("flacc_rdy", 32'(dmem_rdy), 32'd0);
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flacc_re",  32'(dcache_re), 32'd0);
    chk("flacc_rdy2", 32'(dmem_rdy), 32'd1);
    $display("op flush_vs_accept addr=0x00000500");

    // issue_valid and wb_rdy together outside RESP; then flush in RESP.
    issue_valid = 1'b1; issue_addr = 32'h600; issue_tag = 6'd12;
    dcache_dout = 32'h01020304; wb_rdy = 1'b1;
    #1;
    chk("both_wbv", 32'(wb_valid), 32'd0);
    tick();
    issue_valid = 1'b0; wb_rdy = 1'b0;
    chk("both_acc_wbv", 32'(wb_valid), 32'd0);
    chk("both_acc_re",  32'(dcache_re), 32'd1);
    tick();
    tick();
    chk("flr_wbv_pre", 32'(wb_valid), 32'd1);
    chk("flr_data",    wb_data,       32'h01020304);
    flush = 1'b1;
    #1;
    chk("flr_wbv", 32'(wb_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flr_rdy", 32'(dmem_rdy), 32'd1);
    chk("flr_wbv2", 32'(wb_valid), 32'd0);
    $display("op flush_resp addr=0x00000600");

    // Asynchronous reset mid-ACCESS drops the write at once; op is lost.
    issue_valid = 1'b1; issue_addr = 32'h700; issue_wdata = 32'h77;
    issue_funct3 = 3'b010; issue_is_store = 1'b1; issue_tag = 6'd13;
    tick();
    issue_valid = 1'b0; dcache_stall = 1'b1;
    chk("ar_pre_we", 32'(dcache_we), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("ar_we",  32'(dcache_we), 32'd0);
    chk("ar_rdy", 32'(dmem_rdy),  32'd1);
    chk("ar_tag", 32'(wb_tag),    32'd0);
    #1 rst = 1'b0; dcache_stall = 1'b0;
    tick();
    chk("ar_wbv",  32'(wb_valid), 32'd0);
    chk("ar_we2",  32'(dcache_we), 32'd0);
    chk("ar_rdy2", 32'(dmem_rdy), 32'd1);
    $display("op async_reset addr=0x00000700");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
